// File: rtl/div_arbiter.sv
// div_arbiter: round-robin front end that shares one iterative divider among NREQ requesters.
// Divide-by-zero is answered locally; each requester keeps its own result until it is consumed.
module div_arbiter #(
    parameter int BITS = 4,
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_vld,
    output logic [NREQ-1:0]      req_rdy,
    input  logic [NREQ*BITS-1:0] req_a,
    input  logic [NREQ*BITS-1:0] req_b,
    output logic [NREQ-1:0]      res_vld,
    input  logic [NREQ-1:0]      res_rdy,
    output logic [NREQ*BITS-1:0] res_q,
    output logic [NREQ*BITS-1:0] res_r,
    output logic [NREQ-1:0]      res_dz,
    output logic [BITS-1:0]      div_a,
    output logic [BITS-1:0]      div_b,
    output logic                 div_input_vld,
    input  logic                 div_output_vld,
    input  logic [BITS-1:0]      div_q,
    input  logic [BITS-1:0]      div_r
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ZERO  = 2'd3;

    localparam logic [IW-1:0] RR_INIT = IW'(NREQ - 1);

    logic [1:0]           state_q, state_d;
    logic [IW-1:0]        rr_q, rr_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [BITS-1:0]      div_a_q, div_a_d;
    logic [BITS-1:0]      div_b_q, div_b_d;
    logic                 busy_seen_q, busy_seen_d;
    logic [NREQ-1:0]      res_vld_q, res_vld_d;
    logic [NREQ*BITS-1:0] res_quo_q, res_quo_d;
    logic [NREQ*BITS-1:0] res_rem_q, res_rem_d;
    logic [NREQ-1:0]      res_dz_q, res_dz_d;

    logic [NREQ-1:0]      cand;
    logic                 gnt_found;
    logic [IW-1:0]        gnt_idx;
    logic [BITS-1:0]      gnt_a;
    logic [BITS-1:0]      gnt_b;

    // The divider may still be busy after a reset, so idle alone is not enough to accept.
    assign req_rdy = {NREQ{(state_q == S_IDLE) && div_output_vld}} & ~res_vld_q;
    assign cand    = req_vld & req_rdy;

    // Search starts one past the last grant and wraps, so every requester gets a turn.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!gnt_found && cand[(int'(rr_q) + k) % NREQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'((int'(rr_q) + k) % NREQ);
            end
        end
    end

    assign gnt_a = req_a[int'(gnt_idx)*BITS +: BITS];
    assign gnt_b = req_b[int'(gnt_idx)*BITS +: BITS];

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        owner_d     = owner_q;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        busy_seen_d = busy_seen_q;
        res_vld_d   = res_vld_q;
        res_quo_d   = res_quo_q;
        res_rem_d   = res_rem_q;
        res_dz_d    = res_dz_q;

        for (int i = 0; i < NREQ; i++) begin
            if (res_vld_q[i] && res_rdy[i]) begin
                res_vld_d[i] = 1'b0;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    owner_d = gnt_idx;
                    rr_d    = gnt_idx;
                    div_a_d = gnt_a;
                    div_b_d = gnt_b;
                    state_d = (gnt_b == '0) ? S_ZERO : S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy_seen_d = 1'b0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                // Only a low-then-high output_vld marks completion of this operation.
                if (!div_output_vld) begin
                    busy_seen_d = 1'b1;
                end
                if (busy_seen_q && div_output_vld) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (owner_q == IW'(i)) begin
                            res_vld_d[i]            = 1'b1;
                            res_dz_d[i]             = 1'b0;
                            res_quo_d[i*BITS +: BITS] = div_q;
                            res_rem_d[i*BITS +: BITS] = div_r;
                        end
                    end
                    state_d = S_IDLE;
                end
            end
            S_ZERO: begin
                for (int i = 0; i < NREQ; i++) begin
                    if (owner_q == IW'(i)) begin
                        res_vld_d[i]            = 1'b1;
                        res_dz_d[i]             = 1'b1;
                        res_quo_d[i*BITS +: BITS] = {BITS{1'b1}};
                        res_rem_d[i*BITS +: BITS] = div_a_q;
                    end
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_q        <= RR_INIT;
            owner_q     <= '0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            busy_seen_q <= 1'b0;
            res_vld_q   <= '0;
            res_quo_q   <= '0;
            res_rem_q   <= '0;
            res_dz_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            owner_q     <= owner_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            busy_seen_q <= busy_seen_d;
            res_vld_q   <= res_vld_d;
            res_quo_q   <= res_quo_d;
            res_rem_q   <= res_rem_d;
            res_dz_q    <= res_dz_d;
        end
    end

    assign div_input_vld = (state_q == S_ISSUE);
    assign div_a         = div_a_q;
    assign div_b         = div_b_q;
    assign res_vld       = res_vld_q;
    assign res_q         = res_quo_q;
    assign res_r         = res_rem_q;
    assign res_dz        = res_dz_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: two instances (2 and 4 requesters) each driving a behavioural
// BITS-cycle divider; results are scored against an expected-result queue in completion order.
module tb_div_arbiter;
    localparam int BITS     = 8;
    localparam int LAT_NORM = BITS + 2;
    localparam int LAT_DZ   = 1;

    typedef struct {
        int idx;
        int q;
        int r;
        int dz;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int   n_chk    = 0;
    int   n_fail   = 0;
    int   a_pulses = 0;
    int   a_seen   = 0;
    int   b_seen   = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];

    // instance A: two requesters
    logic [1:0]  a_req_vld, a_req_rdy, a_res_vld, a_res_rdy, a_res_dz;
    logic [15:0] a_req_a, a_req_b, a_res_q, a_res_r;
    logic [7:0]  a_div_a, a_div_b;
    logic [7:0]  a_div_q = '0;
    logic [7:0]  a_div_r = '0;
    logic        a_div_in, a_div_out;

    // instance B: four requesters
    logic [3:0]  b_req_vld, b_req_rdy, b_res_vld, b_res_rdy, b_res_dz;
    logic [31:0] b_req_a, b_req_b, b_res_q, b_res_r;
    logic [7:0]  b_div_a, b_div_b;
    logic [7:0]  b_div_q = '0;
    logic [7:0]  b_div_r = '0;
    logic        b_div_in, b_div_out;

    div_arbiter #(.BITS(BITS), .NREQ(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_vld(a_req_vld), .req_rdy(a_req_rdy), .req_a(a_req_a), .req_b(a_req_b),
        .res_vld(a_res_vld), .res_rdy(a_res_rdy), .res_q(a_res_q), .res_r(a_res_r),
        .res_dz(a_res_dz), .div_a(a_div_a), .div_b(a_div_b),
        .div_input_vld(a_div_in), .div_output_vld(a_div_out),
        .div_q(a_div_q), .div_r(a_div_r)
    );

    div_arbiter #(.BITS(BITS), .NREQ(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_vld(b_req_vld), .req_rdy(b_req_rdy), .req_a(b_req_a), .req_b(b_req_b),
        .res_vld(b_res_vld), .res_rdy(b_res_rdy), .res_q(b_res_q), .res_r(b_res_r),
        .res_dz(b_res_dz), .div_a(b_div_a), .div_b(b_div_b),
        .div_input_vld(b_div_in), .div_output_vld(b_div_out),
        .div_q(b_div_q), .div_r(b_div_r)
    );

    // Behavioural dividers: no reset, busy for BITS cycles starting at the edge that sees input_vld.
    logic a_act = 1'b0;
    int   a_cnt = 0;
    assign a_div_out = ~a_act;
    always @(posedge clk) begin
        if (!a_act) begin
            if (a_div_in) begin a_act <= 1'b1; a_cnt <= BITS - 1; end
        end else if (a_cnt == 0) begin
            a_act   <= 1'b0;
            a_div_q <= (a_div_b == 0) ? 8'hff : a_div_a / a_div_b;
            a_div_r <= (a_div_b == 0) ? a_div_a : a_div_a % a_div_b;
        end else begin
            a_cnt <= a_cnt - 1;
        end
    end

    logic b_act = 1'b0;
    int   b_cnt = 0;
    assign b_div_out = ~b_act;
    always @(posedge clk) begin
        if (!b_act) begin
            if (b_div_in) begin b_act <= 1'b1; b_cnt <= BITS - 1; end
        end else if (b_cnt == 0) begin
            b_act   <= 1'b0;
            b_div_q <= (b_div_b == 0) ? 8'hff : b_div_a / b_div_b;
            b_div_r <= (b_div_b == 0) ? b_div_a : b_div_a % b_div_b;
        end else begin
            b_cnt <= b_cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, required %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int i, input int a, input int b);
        exp_t e;
        e.idx = i;
        if (b == 0) begin e.q = 255; e.r = a; e.dz = 1; end
        else begin e.q = a / b; e.r = a % b; e.dz = 0; end
        return e;
    endfunction

    // Scoreboard monitors: every rising res_vld pops the next expected completion.
    logic [1:0] a_prev = '0;
    always @(negedge clk) begin : mon_a
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (a_res_vld[i] && !a_prev[i]) begin
                a_seen++;
                if (sb_a.size() == 0) chk("a_sb_nonempty", sb_a.size(), 1);
                else begin
                    e = sb_a.pop_front();
                    chk("a_owner", i, e.idx);
                    chk("a_q", a_res_q[i*8 +: 8], e.q);
                    chk("a_r", a_res_r[i*8 +: 8], e.r);
                    chk("a_dz", a_res_dz[i], e.dz);
                end
            end
        end
        a_prev = a_res_vld;
        if (a_div_in) a_pulses++;
    end

    logic [3:0] b_prev = '0;
    always @(negedge clk) begin : mon_b
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (b_res_vld[i] && !b_prev[i]) begin
                b_seen++;
                if (sb_b.size() == 0) chk("b_sb_nonempty", sb_b.size(), 1);
                else begin
                    e = sb_b.pop_front();
                    chk("b_owner", i, e.idx);
                    chk("b_q", b_res_q[i*8 +: 8], e.q);
                    chk("b_r", b_res_r[i*8 +: 8], e.r);
                    chk("b_dz", b_res_dz[i], e.dz);
                end
            end
        end
        b_prev = b_res_vld;
    end

    // Single request on A; checks latency from the accept edge and the number of start pulses.
    task automatic do_req(input int i, input int av, input int bv, input int lat);
        int n;
        int p0;
        @(negedge clk);
        chk("acc_rdy", a_req_rdy[i], 1);
        a_req_a[i*8 +: 8] = 8'(av);
        a_req_b[i*8 +: 8] = 8'(bv);
        a_req_vld[i]      = 1'b1;
        sb_a.push_back(mk(i, av, bv));
        p0 = a_pulses;
        n  = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!a_res_vld[i] && n < 60);
        chk("latency", n - 1, lat);
        @(negedge clk);
        a_req_vld[i] = 1'b0;
        chk("start_pulses", a_pulses - p0, (bv == 0) ? 0 : 1);
    endtask

    task automatic do_pair(input int a0, input int b0, input int a1, input int b1, input int first);
        int n;
        @(negedge clk);
        a_req_a   = {8'(a1), 8'(a0)};
        a_req_b   = {8'(b1), 8'(b0)};
        a_req_vld = 2'b11;
        if (first == 0) begin
            sb_a.push_back(mk(0, a0, b0));
            sb_a.push_back(mk(1, a1, b1));
        end else begin
            sb_a.push_back(mk(1, a1, b1));
            sb_a.push_back(mk(0, a0, b0));
        end
        n = 0;
        while (a_req_vld != 2'b00 && n < 100) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < 2; i++) if (a_res_vld[i]) a_req_vld[i] = 1'b0;
        end
        chk("pair_done", a_req_vld, 0);
    endtask

    initial begin
        int n;
        a_req_vld = '0; a_req_a = '0; a_req_b = '0; a_res_rdy = '1;
        b_req_vld = '0; b_req_a = '0; b_req_b = '0; b_res_rdy = '1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        chk("rst_res_vld", a_res_vld, 0);
        chk("rst_res_q", a_res_q, 0);
        chk("rst_res_r", a_res_r, 0);
        chk("rst_res_dz", a_res_dz, 0);
        chk("rst_div_a", a_div_a, 0);
        chk("rst_div_b", a_div_b, 0);
        chk("rst_div_in", a_div_in, 0);
        chk("rst_rdy_a", a_req_rdy, 2'b11);
        chk("rst_rdy_b", b_req_rdy, 4'hf);

        // right after reset requester 0 wins, then requester 1
        do_pair(200, 7, 255, 16, 0);
        do_req(0, 13, 3, LAT_NORM);
        // pointer now at 0, so requester 1 wins a tie
        do_pair(200, 7, 255, 16, 1);
        do_req(1, 77, 0, LAT_DZ);

        // requester 0 result held; requester 1 proceeds independently
        @(negedge clk);
        a_res_rdy[0] = 1'b0;
        a_req_a[7:0] = 8'd50; a_req_b[7:0] = 8'd6; a_req_vld[0] = 1'b1;
        sb_a.push_back(mk(0, 50, 6));
        n = 0;
        while (!a_res_vld[0] && n < 60) begin @(negedge clk); n++; end
        chk("held_arrived", a_res_vld[0], 1);
        a_req_vld[0] = 1'b0;
        chk("held_rdy0", a_req_rdy[0], 0);
        do_req(1, 100, 9, LAT_NORM);
        chk("held_vld0", a_res_vld[0], 1);
        chk("held_q0", a_res_q[7:0], 8);
        chk("held_r0", a_res_r[7:0], 2);
        @(negedge clk);
        a_res_rdy[0] = 1'b1;
        @(posedge clk); #1;
        chk("consume_vld0", a_res_vld[0], 0);
        chk("consume_q0", a_res_q[7:0], 8);
        chk("consume_r0", a_res_r[7:0], 2);

        // reset three cycles into WAIT while the divider is busy
        @(negedge clk);
        a_req_a[7:0] = 8'd30; a_req_b[7:0] = 8'd4; a_req_vld[0] = 1'b1;
        @(posedge clk); #1;
        chk("mid_accepted", a_req_rdy[0], 0);
        @(negedge clk);
        a_req_vld[0] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_res_vld", a_res_vld, 0);
        chk("mid_rst_div_in", a_div_in, 0);
        chk("mid_rst_div_busy", a_div_out, 0);
        a_req_a[7:0] = 8'd9; a_req_b[7:0] = 8'd2; a_req_vld[0] = 1'b1;
        sb_a.push_back(mk(0, 9, 2));
        n = 0;
        while (!a_div_out && n < 40) begin
            chk("no_grant_busy", a_req_rdy[0], 0);
            @(negedge clk);
            n++;
        end
        chk("idle_rdy1", a_req_rdy[1], 1);
        n = 0;
        while (!a_res_vld[0] && n < 60) begin @(negedge clk); n++; end
        chk("post_rst_done", a_res_vld[0], 1);
        a_req_vld[0] = 1'b0;

        // four requesters held valid continuously
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            b_req_a[i*8 +: 8] = 8'((i + 1) * 20 + 3);
            b_req_b[i*8 +: 8] = 8'(i + 2);
        end
        for (int k = 0; k < 5; k++) sb_b.push_back(mk(k % 4, ((k % 4) + 1) * 20 + 3, (k % 4) + 2));
        b_req_vld = 4'hf;
        n = 0;
        while (b_seen < 5 && n < 500) begin @(negedge clk); #1; n++; end
        b_req_vld = 4'h0;
        chk("b_five_results", b_seen, 5);

        repeat (30) @(negedge clk);
        chk("a_sb_drained", sb_a.size(), 0);
        chk("b_sb_drained", sb_b.size(), 0);
        chk("b_no_extra", b_seen, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
